// File: rtl/cbm_drive_pkg.sv
// Shared types for the CBM multi-drive track controller.
// Half-track/track widths, drive index and stepper move codes.
package cbm_drive_pkg;

  typedef logic [6:0] halftrack_t;
  typedef logic [5:0] track_t;
  typedef logic [1:0] drive_idx_t;
  typedef logic [1:0] step_move_t;

  localparam step_move_t MOVE_UP = 2'd1;
  localparam step_move_t MOVE_DN = 2'd3;

  typedef enum logic {
    ARB_IDLE,
    ARB_REQ
  } arb_state_e;

  function automatic track_t ht2trk(halftrack_t ht);
    return ht[6:1];
  endfunction

endpackage

// File: rtl/cbm_drive_stepper.sv
// Per-drive head position, dirty/pending save state,
// disk-change latch and write-protect blink counter.
module cbm_drive_stepper
  import cbm_drive_pkg::*;
#(
  parameter int MAX_HALFTRACK  = 80,
  parameter int INIT_HALFTRACK = 36,
  parameter int TIMEOUT_W      = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_i,
  input  logic [1:0] stp_i,
  input  logic       mtr_i,
  input  logic       act_i,
  input  logic       we_i,
  input  logic       img_mounted_i,
  input  logic       img_readonly_i,
  input  logic       img_present_i,
  input  logic       grant_i,
  output track_t     track_o,
  output logic       tr00_n_o,
  output logic       wps_n_o,
  output logic       present_o,
  output logic       pend_o,
  output track_t     pend_trk_o,
  output logic       overrun_o
);

  localparam halftrack_t HT_MAX  = halftrack_t'(MAX_HALFTRACK);
  localparam halftrack_t HT_INIT = halftrack_t'(INIT_HALFTRACK);
  localparam logic [TIMEOUT_W-1:0] CNT_FULL = '1;

  step_move_t stp_q;
  halftrack_t ht_q, ht_d;
  track_t     trk_q;
  track_t     ptrk_q, ptrk_d;
  logic       act_q, mnt_q;
  logic       dirty_q, dirty_d;
  logic       pend_q, pend_d;
  logic       ovr_q, ovr_d;
  logic       ro_q, ro_d;
  logic       pres_q, pres_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  step_move_t move;
  logic       up, dn, act_fall, mount, evt;

  always_comb begin
    move     = stp_i - stp_q;
    up       = mtr_i && (move == MOVE_UP);
    dn       = mtr_i && (move == MOVE_DN);
    act_fall = act_q && !act_i;
    mount    = img_mounted_i && !mnt_q;
    evt      = dirty_q && (up || dn || act_fall);

    ht_d = ht_q;
    unique case (1'b1)
      up && (ht_q < HT_MAX): ht_d = ht_q + 7'd1;
      dn && (ht_q != '0):    ht_d = ht_q - 7'd1;
      default: ;
    endcase

    dirty_d = dirty_q;
    pend_d  = pend_q && !grant_i;
    ptrk_d  = ptrk_q;
    ovr_d   = ovr_q;
    // Saturated steps still count: the event keys off the decode.
    if (evt) begin
      dirty_d = 1'b0;
      if (pend_q && !grant_i) begin
        ovr_d = 1'b1;
      end else begin
        pend_d = 1'b1;
        ptrk_d = ht2trk(ht_q);
      end
    end
    if (we_i) dirty_d = 1'b1;

    ro_d   = ro_q;
    pres_d = pres_q;
    cnt_d  = cnt_q;
    if (mount) begin
      dirty_d = 1'b0;
      pend_d  = 1'b0;
      ro_d    = img_readonly_i;
      pres_d  = img_present_i;
      cnt_d   = CNT_FULL;
    end else if (ce_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Read-only resets high so an empty drive reports protected.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stp_q   <= '0;
      ht_q    <= HT_INIT;
      trk_q   <= ht2trk(HT_INIT);
      act_q   <= 1'b0;
      mnt_q   <= 1'b0;
      dirty_q <= 1'b0;
      pend_q  <= 1'b0;
      ptrk_q  <= '0;
      ovr_q   <= 1'b0;
      ro_q    <= 1'b1;
      pres_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      stp_q   <= stp_i;
      ht_q    <= ht_d;
      trk_q   <= ht2trk(ht_q);
      act_q   <= act_i;
      mnt_q   <= img_mounted_i;
      dirty_q <= dirty_d;
      pend_q  <= pend_d;
      ptrk_q  <= ptrk_d;
      ovr_q   <= ovr_d;
      ro_q    <= ro_d;
      pres_q  <= pres_d;
      cnt_q   <= cnt_d;
    end
  end

  assign track_o    = trk_q;
  assign tr00_n_o   = (trk_q != '0);
  assign wps_n_o    = ~ro_q ^ cnt_q[TIMEOUT_W-2];
  assign present_o  = pres_q;
  assign pend_o     = pend_q;
  assign pend_trk_o = ptrk_q;
  assign overrun_o  = ovr_q;

endmodule

// File: rtl/cbm_track_ctrl.sv
// Multi-drive track controller: per-drive steppers plus a
// round-robin arbiter onto the shared SD save channel.
module cbm_track_ctrl
  import cbm_drive_pkg::*;
#(
  parameter int DRIVES         = 2,
  parameter int MAX_HALFTRACK  = 80,
  parameter int INIT_HALFTRACK = 36,
  parameter int TIMEOUT_W      = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ce,
  input  logic [2*DRIVES-1:0] stp,
  input  logic [DRIVES-1:0]   mtr,
  input  logic [DRIVES-1:0]   act,
  input  logic [DRIVES-1:0]   we,
  input  logic [DRIVES-1:0]   img_mounted,
  input  logic [DRIVES-1:0]   img_readonly,
  input  logic [DRIVES-1:0]   img_present,
  output logic [6*DRIVES-1:0] track,
  output logic [DRIVES-1:0]   tr00_sense_n,
  output logic [DRIVES-1:0]   wps_n,
  output logic [DRIVES-1:0]   disk_present,
  output logic                save_req,
  output logic [1:0]          save_drive,
  output logic [5:0]          save_track,
  input  logic                save_ack,
  output logic [DRIVES-1:0]   overrun
);

  logic [DRIVES-1:0] pend;
  logic [DRIVES-1:0] grant;
  logic [3:0]        pend4;
  track_t            pend_trk [4];

  arb_state_e state_q, state_d;
  drive_idx_t last_q, last_d;
  drive_idx_t drv_q, drv_d;
  track_t     trk_q, trk_d;
  drive_idx_t sel, idx;
  logic       hit;

  for (genvar d = 0; d < 4; d++) begin : g_drv
    if (d < DRIVES) begin : g_on
      cbm_drive_stepper #(
        .MAX_HALFTRACK (MAX_HALFTRACK),
        .INIT_HALFTRACK(INIT_HALFTRACK),
        .TIMEOUT_W     (TIMEOUT_W)
      ) u_stepper (
        .clk           (clk),
        .reset_n       (reset_n),
        .ce_i          (ce),
        .stp_i         (stp[2*d +: 2]),
        .mtr_i         (mtr[d]),
        .act_i         (act[d]),
        .we_i          (we[d]),
        .img_mounted_i (img_mounted[d]),
        .img_readonly_i(img_readonly[d]),
        .img_present_i (img_present[d]),
        .grant_i       (grant[d]),
        .track_o       (track[6*d +: 6]),
        .tr00_n_o      (tr00_sense_n[d]),
        .wps_n_o       (wps_n[d]),
        .present_o     (disk_present[d]),
        .pend_o        (pend[d]),
        .pend_trk_o    (pend_trk[d]),
        .overrun_o     (overrun[d])
      );
      assign grant[d] = (state_q == ARB_IDLE) && hit &&
                        (sel == drive_idx_t'(d));
    end else begin : g_off
      assign pend_trk[d] = '0;
    end
  end

  assign pend4 = 4'(pend);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    drv_d   = drv_q;
    trk_d   = trk_q;
    hit     = 1'b0;
    sel     = last_q;
    idx     = '0;
    // Scan starts one past the last granted drive.
    for (int i = 1; i <= DRIVES; i++) begin
      idx = drive_idx_t'((int'(last_q) + i) % DRIVES);
      if (!hit && pend4[idx]) begin
        hit = 1'b1;
        sel = idx;
      end
    end
    unique case (state_q)
      ARB_IDLE: begin
        if (hit) begin
          drv_d   = sel;
          trk_d   = pend_trk[sel];
          state_d = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (save_ack) begin
          last_d  = drv_q;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      last_q  <= drive_idx_t'(DRIVES - 1);
      drv_q   <= '0;
      trk_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      drv_q   <= drv_d;
      trk_q   <= trk_d;
    end
  end

  assign save_req   = (state_q == ARB_REQ);
  assign save_drive = drv_q;
  assign save_track = trk_q;

endmodule

// File: doc/cbm_track_ctrl.md
# cbm_track_ctrl

Multi-drive head-position and track-writeback controller for the CBM disk-drive cores. For each of `DRIVES` emulated drives it decodes the 2-bit stepper phase into a half-track position and tracks whether the current track has been written. It schedules dirty-track saves to the shared SD track loader through a single round-robin req/ack channel, and generates the disk-change write-protect blink. It sits between the per-drive logic/GCR blocks and the shared SD track engine.

## Interface
- `DRIVES`, 2: number of drives, 1..4.
- `MAX_HALFTRACK`, 80: highest reachable half-track.
- `INIT_HALFTRACK`, 36: half-track loaded at reset (track 18).
- `TIMEOUT_W`, 24: width of the disk-change blink counter.
- `clk`  in  1: core clock.
- `reset_n`  in  1: synchronous, active-low reset on clock `clk`.
- `ce`  in  1: drive clock enable; only the blink counter uses it.
- `stp`  in  2*DRIVES: stepper phase per drive, `[2d+1:2d]`.
- `mtr`  in  DRIVES: spindle motor on.
- `act`  in  DRIVES: drive activity LED.
- `we`  in  DRIVES: GCR write strobe, one cycle per byte.
- `img_mounted`  in  DRIVES: mount pulse; rising edge = disk change.
- `img_readonly`  in  DRIVES: sampled on the mount edge.
- `img_present`  in  DRIVES: image size ≠ 0; sampled on the mount edge.
- `track`  out  6*DRIVES: current full track, equal to half-track >> 1.
- `tr00_sense_n`  out  DRIVES: 0 when the drive is on track 0.
- `wps_n`  out  DRIVES: write-protect sense, active-low.
- `disk_present`  out  DRIVES: latched `img_present`.
- `save_req`  out  1: save request.
- `save_drive`  out  2: drive index of the request.
- `save_track`  out  6: track number to write back.
- `save_ack`  in  1: one-cycle acceptance from the SD engine.
- `overrun`  out  DRIVES: sticky flag; a save event was dropped.

## Operation
- **Stepper decode**
  - Per drive: register `stp_old`, then compute `move = stp - stp_old` modulo 4.
  - Only when `mtr=1`:
    - `move=1`: half-track +1, saturating at `MAX_HALFTRACK`.
    - `move=3`: half-track −1, saturating at 0.
    - `move=0` or `move=2`: no motion.
- **Dirty tracking**
  - `we=1` sets `dirty`.
  - A **save event** occurs on either of these, when `dirty=1`:
    - a decoded step, evaluated before saturation (a step that saturates still counts);
    - the `act` falling edge.
  - On a save event: capture the *pre-step* track into `pend_trk`, set `pend`, clear `dirty`.
  - `we` in the same cycle as a save event re-sets `dirty` for the new position.
  - Step and `act` fall in the same cycle produce one event.
- **Pending overflow**
  - A save event while `pend=1` and not yet granted is dropped.
  - The dropped event sets `overrun[d]`, which clears only on reset.
  - `dirty` is still cleared.
- **Disk change**
  - The `img_mounted` rising edge does all of the following:
    - latches `readonly` and `disk_present`;
    - clears `dirty` and `pend`;
    - loads the blink counter with all-ones.
  - A request already in flight for that drive is not withdrawn.
- **Write protect**
  - The blink counter decrements on `ce` while non-zero.
  - `wps_n = ~readonly ^ cnt[TIMEOUT_W-2]`.
- **Arbiter**
  - States are IDLE and REQ.
  - IDLE: scan `pend` round-robin, starting at `last_grant+1`. On a hit:
    - load `save_drive` and `save_track`;
    - clear that drive's `pend`;
    - go to REQ.
  - REQ: hold `save_req=1` with stable fields until `save_ack=1`, then go to IDLE and set `last_grant`.
  - `save_ack` outside REQ is ignored.

## Timing
- **Reset values**
  - All outputs 0, except `track` = `INIT_HALFTRACK>>1` and `tr00_sense_n` = 1 (for nonzero init).
  - Half-track = `INIT_HALFTRACK`; `dirty`, `pend`, `overrun`, counters = 0; `last_grant = DRIVES-1`.
  - Arbiter in IDLE.
- **Reset mid-request**: `save_req` drops in the cycle after `reset_n` is sampled low.
- **Step latency**
  - `stp` change → half-track update: 1 cycle.
  - `track` output: 1 further cycle (2 total).
  - `tr00_sense_n` is derived from the registered `track` output.
- **Save latency**
  - Event → `pend`: 1 cycle.
  - `pend` → `save_req` high: 1 cycle, when in IDLE.
- **Handshake spacing**: `save_req` is low for at least one cycle after the ack cycle.
- **Mount edge**: takes effect 1 cycle after the edge.

## Structure
- **Package `cbm_drive_pkg`**: `halftrack_t` (7 bits), `track_t` (6 bits), `drive_idx_t` (2 bits), stepper move constants.
- **Sub-module `cbm_drive_stepper`**: one per drive via generate. Contains stepper decode, dirty/pend/overrun, disk-change and blink logic.
- **Top level**: round-robin arbiter plus output packing.

## Test plan
- **Stepping**: `DRIVES=2`, `mtr=1`; drive 0 `stp` 0→1→2→3 → half-track 36→39, `track`=19. Then `stp`=2 → half-track 38. With `mtr=0`, steps are ignored.
- **Saturation**: step drive 1 down 40 times → half-track 0, `track`=0, `tr00_sense_n`=0. A further down-step does not move.
- **Save on step**: `we` pulse on drive 0 at track 18, then step up twice → `save_req`, `save_drive`=0, `save_track`=18. Hold `save_ack` low 10 cycles → fields stable. Ack → `save_req` low next cycle.
- **Round-robin**: both drives dirty; `act` falls on both in the same cycle → grants drive 0 then drive 1. Next simultaneous pair → drive 0 then drive 1 again (`last_grant`=1).
- **Overrun and mount**:
  - Drive 0 has `pend` set while the arbiter is busy with drive 1, and a second event arrives → `overrun[0]`=1 and the first `save_track` is preserved.
  - Mount on drive 0 during a pending save → `pend` cleared, no request issued.
- **Write-protect blink**: `TIMEOUT_W=4`, `ce` always 1, `img_readonly`=0 → `wps_n` toggles per bit 2 for 15 cycles, then settles at 1.
